tlb_fill_decoder: RTL
=====================

# tlb_fill_decoder

Binary-to-one-hot fill/invalidate controller for a 16-entry fully associative structure (TLB, victim buffer). Accepts fill requests with an explicit or round-robin-chosen index, decodes the index to one-hot write strobes, tracks a per-entry valid vector, and runs a multi-cycle flush sweep. It sits between the miss/refill logic, which supplies binary indices, and the entry array, which consumes one-hot enables. It is the decode-side counterpart of the design's one-hot-to-binary encoders.

## Interface
Parameters:
- N_ENTRY, 16, entry count; fixed, from the shared package.
- IDX_W, 4, index width, log2(N_ENTRY).

Ports:
- clk  in  1  clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  fill request.
- req_ready  out  1  `state==IDLE && !flush_req && !reset`; combinational.
- req_use_idx  in  1  1 = use req_idx; 0 = controller picks the victim.
- req_idx  in  4  explicit fill index.
- inv_valid  in  1  single-entry invalidate; no handshake, sampled in IDLE only.
- inv_idx  in  4  index to invalidate.
- flush_req  in  1  start the flush sweep; sampled in IDLE only.
- we_valid  out  1  registered one-cycle fill strobe.
- we_onehot  out  16  decoded fill enable.
- we_idx  out  4  resolved fill index.
- clr_valid  out  1  registered one-cycle clear strobe (single invalidate or flush step).
- clr_onehot  out  16  decoded clear enable.
- entry_valid  out  16  per-entry valid register.
- rr_ptr  out  4  round-robin pointer.
- busy  out  1  `state==FLUSH`.

## Operation
- States:
  - IDLE: fills, invalidates and flush start are accepted.
  - FLUSH: 16-cycle sweep with a 4-bit counter `fcnt`.
- Fill accepted when `req_valid && req_ready`. Victim selection uses `entry_valid` as registered at the start of the cycle:
  - `req_use_idx=1`: use req_idx.
  - `req_use_idx=0` with an invalid entry: lowest-numbered invalid entry.
  - `req_use_idx=0` with all entries valid: rr_ptr, then rr_ptr increments mod 16 (15 wraps to 0). This is the only event that moves rr_ptr.
- Single invalidate (IDLE, `inv_valid`):
  - Clears `entry_valid[inv_idx]` and pulses clr.
  - If a fill is accepted in the same cycle to the same resolved index, the invalidate is dropped: no clr pulse, entry ends valid.
  - Different indices: both take effect.
- Flush (IDLE, `flush_req`):
  - Any same-cycle fill is refused (req_ready=0). Any same-cycle inv_valid is ignored.
  - Next state FLUSH with `fcnt=0`. Each FLUSH cycle registers a clr strobe for entry `fcnt`, then increments `fcnt`.
  - After `fcnt=15`, return to IDLE.
  - flush_req and inv_valid are ignored while in FLUSH.
- Reset, including mid-flush: next cycle state=IDLE; entry_valid, rr_ptr, fcnt, and all strobes/onehots/indices are 0.

## Timing
- Fill accepted in cycle T:
  - we_valid=1 with we_onehot and we_idx in T+1 only.
  - `entry_valid[idx]=1` visible in T+1.
  - Back-to-back fills are accepted every cycle, and victim selection sees all earlier fills.
- Invalidate in T: clr strobe and the cleared bit are both visible in T+1.
- Flush requested in T:
  - req_ready=0 in T.
  - busy=1 in T+1..T+16.
  - clr_onehot=`1<<k` in cycle T+1+k, with `entry_valid[k]` cleared in that same cycle.
  - busy=0 and req_ready=1 in T+17.
- Strobe outputs are 0 in every cycle without an event; onehots are 0 when their valid is 0.

## Structure
- Shared package holds N_ENTRY, IDX_W and the state encoding (IDLE=0, FLUSH=1).
- One sub-module, `decoder_4_16`: purely combinational binary-to-one-hot decoder. It is instanced for the fill path and the clear path.
- The lowest-invalid priority finder is inline logic.

## Test plan
- Reset, then 16 back-to-back round-robin fills -> we_idx 0..15, we_onehot 0x0001..0x8000, entry_valid=0xFFFF, rr_ptr=0. Two more fills -> idx 0 then 1, rr_ptr=2.
- Explicit fill with req_idx=9 on an empty array -> we_onehot=0x0200, entry_valid=0x0200, rr_ptr unchanged. A following round-robin fill -> idx 0.
- Full array, inv_idx=3 -> clr_onehot=0x0008, entry_valid=0xFFF7. Next round-robin fill -> idx 3, rr_ptr unchanged.
- flush_req and req_valid together in T on a full array:
  - fill refused in T;
  - clr strobes 0x0001..0x8000 in T+1..T+16;
  - entry_valid=0 at T+16;
  - req_ready=1 at T+17.
- Explicit fill idx 5 with inv_idx=5 in the same cycle -> bit 5 set, no clr pulse. Fill idx 5 with inv_idx=6 -> we_onehot=0x0020 and clr_onehot=0x0040.
- Reset asserted in flush step 8 -> next cycle busy=0, entry_valid=0, strobes=0, req_ready=1 once reset drops.

Source files
------------

// File: rtl/tlb_fill_decoder_pkg.sv
// Shared constants and FSM encoding for the TLB fill/invalidate controller.
package tlb_fill_decoder_pkg;
    localparam int N_ENTRY = 16;
    localparam int IDX_W   = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;
endpackage

// File: rtl/tlb_fill_decoder_decoder_4_16.sv
// Combinational binary-to-one-hot decoder; output is all zero when en is low.
module decoder_4_16
    import tlb_fill_decoder_pkg::*;
(
    input  logic               en,
    input  logic [IDX_W-1:0]   idx,
    output logic [N_ENTRY-1:0] onehot
);
    assign onehot = en ? (N_ENTRY'(1) << idx) : '0;
endmodule

// File: rtl/tlb_fill_decoder.sv
// Fill/invalidate/flush controller: resolves fill victims, decodes indices to
// one-hot strobes for the entry array and keeps the per-entry valid vector.
module tlb_fill_decoder
    import tlb_fill_decoder_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_use_idx,
    input  logic [IDX_W-1:0]   req_idx,
    input  logic               inv_valid,
    input  logic [IDX_W-1:0]   inv_idx,
    input  logic               flush_req,
    output logic               we_valid,
    output logic [N_ENTRY-1:0] we_onehot,
    output logic [IDX_W-1:0]   we_idx,
    output logic               clr_valid,
    output logic [N_ENTRY-1:0] clr_onehot,
    output logic [N_ENTRY-1:0] entry_valid,
    output logic [IDX_W-1:0]   rr_ptr,
    output logic               busy
);
    state_t             state, state_n;
    logic [IDX_W-1:0]   fcnt, fcnt_n;
    logic [IDX_W-1:0]   rr_n;
    logic [IDX_W-1:0]   low_idx;
    logic [IDX_W-1:0]   fill_idx;
    logic [IDX_W-1:0]   clr_idx_n;
    logic               all_valid;
    logic               accept;
    logic               clr_go;
    logic [N_ENTRY-1:0] fill_oh;
    logic [N_ENTRY-1:0] clr_oh;

    assign busy      = (state == FLUSH);
    assign req_ready = (state == IDLE) && !flush_req && !reset;
    assign accept    = req_valid && req_ready;
    assign all_valid = &entry_valid;

    // Scan high to low so the lowest invalid entry wins.
    always_comb begin
        low_idx = '0;
        for (int i = N_ENTRY - 1; i >= 0; i--) begin
            if (!entry_valid[i]) low_idx = IDX_W'(i);
        end
    end

    assign fill_idx = req_use_idx ? req_idx : (all_valid ? rr_ptr : low_idx);

    always_comb begin
        state_n   = state;
        fcnt_n    = fcnt;
        rr_n      = rr_ptr;
        clr_go    = 1'b0;
        clr_idx_n = '0;
        case (state)
            IDLE: begin
                if (flush_req) begin
                    // Entry 0 is cleared on the way in so clear k lands in FLUSH cycle k.
                    state_n   = FLUSH;
                    fcnt_n    = '0;
                    clr_go    = 1'b1;
                    clr_idx_n = '0;
                end else begin
                    if (accept && !req_use_idx && all_valid) rr_n = rr_ptr + 1'b1;
                    if (inv_valid && !(accept && inv_idx == fill_idx)) begin
                        clr_go    = 1'b1;
                        clr_idx_n = inv_idx;
                    end
                end
            end
            FLUSH: begin
                fcnt_n = fcnt + 1'b1;
                if (fcnt == IDX_W'(N_ENTRY - 1)) begin
                    state_n = IDLE;
                end else begin
                    clr_go    = 1'b1;
                    clr_idx_n = fcnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    decoder_4_16 u_fill_dec (.en(accept), .idx(fill_idx),  .onehot(fill_oh));
    decoder_4_16 u_clr_dec  (.en(clr_go), .idx(clr_idx_n), .onehot(clr_oh));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            fcnt  <= '0;
        end else begin
            state <= state_n;
            fcnt  <= fcnt_n;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            entry_valid <= '0;
            rr_ptr      <= '0;
            we_valid    <= 1'b0;
            we_onehot   <= '0;
            we_idx      <= '0;
            clr_valid   <= 1'b0;
            clr_onehot  <= '0;
        end else begin
            // A same-index fill suppresses its invalidate, so set and clear never collide.
            entry_valid <= (entry_valid | fill_oh) & ~clr_oh;
            rr_ptr      <= rr_n;
            we_valid    <= accept;
            we_onehot   <= fill_oh;
            we_idx      <= accept ? fill_idx : '0;
            clr_valid   <= clr_go;
            clr_onehot  <= clr_oh;
        end
    end
endmodule
